uart_tx_piso: RTL

//   UART transmitter: counterpart to the receive SIPO path. Latches a parallel word and

---
 rtl/uart_tx_piso.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_piso.sv
// UART transmit shifter: latches a parallel word and serialises it as a
// start / data (LSB first) / optional parity / stop frame on baud ticks.
module uart_tx_piso #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    function automatic logic frame_parity(input logic [DATA_BITS-1:0] word);
        return (^word) ^ (PARITY_ODD != 0);
    endfunction

    state_t               state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 parity_r;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic                 stop_cnt_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 done_r;

    // Frame sequencer; tx is registered one state ahead so it changes on the tick edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            shift_r    <= {DATA_BITS{1'b0}};
            parity_r   <= 1'b0;
            bit_cnt_r  <= {CNT_W{1'b0}};
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    tx_r <= 1'b1;
                    // A tick in the accept cycle is deliberately ignored; SYNC absorbs it.
                    if (tx_start) begin
                        shift_r    <= data_in;
                        parity_r   <= frame_parity(data_in);
                        bit_cnt_r  <= {CNT_W{1'b0}};
                        stop_cnt_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (tick) begin
                        tx_r    <= 1'b0;
                        state_r <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx_r      <= shift_r[0];
                        bit_cnt_r <= {CNT_W{1'b0}};
                        state_r   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (bit_cnt_r == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx_r    <= parity_r;
                                state_r <= S_PARITY;
                            end else begin
                                tx_r       <= 1'b1;
                                stop_cnt_r <= 1'b0;
                                state_r    <= S_STOP;
                            end
                        end else begin
                            tx_r <= shift_r[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        tx_r       <= 1'b1;
                        stop_cnt_r <= 1'b0;
                        state_r    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (stop_cnt_r == LAST_STOP) begin
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= S_IDLE;
                        end else begin
                            stop_cnt_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_r;
    assign tx_busy = busy_r;
    assign tx_done = done_r;

endmodule
